// File: rtl/fetch_seq_rstack.sv
// Multi-cycle fetch sequencer: reads opcode (+ optional argument byte) from sync memory, issues it, applies flow control.
// Internal return-address stack; any stack fault or HALT command parks the sequencer until reset.
module fetch_seq_rstack #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    STACK_DEPTH  = 8,
    parameter int                    ARG_FLAG_BIT = 7,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_rd_en,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic [DATA_WIDTH-1:0]          instr_out,
    output logic [DATA_WIDTH-1:0]          arg_out,
    output logic [ADDR_WIDTH-1:0]          instr_pc,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    input  logic                           ctrl_valid,
    input  logic [2:0]                     ctrl_op,
    input  logic [ADDR_WIDTH-1:0]          ctrl_target,
    output logic                           ctrl_ready,
    output logic                           halted,
    output logic [1:0]                     stack_err,
    output logic [$clog2(STACK_DEPTH):0]   stack_level
);
    localparam int LW = $clog2(STACK_DEPTH) + 1;
    localparam int IW = $clog2(STACK_DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(STACK_DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JABS = 3'd1;
    localparam logic [2:0] OP_JREL = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH_OP, S_LATCH_OP, S_LATCH_ARG, S_ISSUE, S_EXEC, S_HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   arg_q, arg_d;
    logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
    logic                    two_q, two_d;
    logic [LW-1:0]           sp_q, sp_d;
    logic [1:0]              err_q, err_d;
    logic                    halted_q, halted_d;
    logic [ADDR_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0]   stack_d [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0]   ret_addr;
    logic [LW-1:0]           sp_m1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        arg_d       = arg_q;
        ipc_d       = ipc_q;
        two_d       = two_q;
        sp_d        = sp_q;
        err_d       = err_q;
        stack_d     = stack_q;
        mem_rd_en   = 1'b0;
        mem_addr    = pc_q;
        instr_valid = 1'b0;
        ctrl_ready  = 1'b0;
        sp_m1       = sp_q - LW'(1);
        ret_addr    = ipc_q + (two_q ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));

        case (state_q)
            S_FETCH_OP: begin
                mem_rd_en = 1'b1;
                state_d   = S_LATCH_OP;
            end
            S_LATCH_OP: begin
                instr_d = mem_rdata;
                ipc_d   = pc_q;
                if (mem_rdata[ARG_FLAG_BIT]) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pc_q + ADDR_WIDTH'(1);
                    two_d     = 1'b1;
                    state_d   = S_LATCH_ARG;
                end else begin
                    arg_d   = '0;
                    two_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_LATCH_ARG: begin
                arg_d   = mem_rdata;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                ctrl_ready = 1'b1;
                if (ctrl_valid) begin
                    state_d = S_FETCH_OP;
                    case (ctrl_op)
                        OP_JABS: pc_d = ctrl_target;
                        OP_JREL: pc_d = ipc_q + ctrl_target;
                        OP_CALL: begin
                            if (sp_q < DEPTH_L) begin
                                stack_d[sp_q[IW-1:0]] = ret_addr;
                                sp_d = sp_q + LW'(1);
                                pc_d = ctrl_target;
                            end else begin
                                err_d[0] = 1'b1;
                                state_d  = S_HALT;
                            end
                        end
                        OP_RET: begin
                            if (sp_q != '0) begin
                                pc_d = stack_q[sp_m1[IW-1:0]];
                                sp_d = sp_m1;
                            end else begin
                                err_d[1] = 1'b1;
                                state_d  = S_HALT;
                            end
                        end
                        OP_HALT: state_d = S_HALT;
                        default: pc_d = ret_addr;  // SEQ and the unused encodings
                    endcase
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH_OP;
        endcase

        // A pending read or handshake must not leak out during the reset cycle
        if (reset) begin
            mem_rd_en   = 1'b0;
            instr_valid = 1'b0;
            ctrl_ready  = 1'b0;
        end
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH_OP;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            arg_q    <= '0;
            ipc_q    <= RESET_PC;
            two_q    <= 1'b0;
            sp_q     <= '0;
            err_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            arg_q    <= arg_d;
            ipc_q    <= ipc_d;
            two_q    <= two_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    // Stack contents are only meaningful below sp_q, so they need no reset
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign instr_out   = instr_q;
    assign arg_out     = arg_q;
    assign instr_pc    = ipc_q;
    assign halted      = halted_q;
    assign stack_err   = err_q;
    assign stack_level = sp_q;
endmodule

// File: tb/tb_fetch_seq_rstack.sv
// Directed bench for fetch_seq_rstack: vector table for the fetch/flow-control path plus
// hand-written sequences for reset, halt and stack faults.
module tb_fetch_seq_rstack;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr_out, arg_out;
    logic [11:0] instr_pc;
    logic        instr_valid, instr_ready;
    logic        ctrl_valid;
    logic [2:0]  ctrl_op;
    logic [11:0] ctrl_target;
    logic        ctrl_ready, halted;
    logic [1:0]  stack_err;
    logic [3:0]  stack_level;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:4095];

    fetch_seq_rstack dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .instr_out(instr_out), .arg_out(arg_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ctrl_valid(ctrl_valid), .ctrl_op(ctrl_op), .ctrl_target(ctrl_target),
        .ctrl_ready(ctrl_ready), .halted(halted), .stack_err(stack_err),
        .stack_level(stack_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [2:0]  op;
        logic [11:0] tgt;
        int          hold;
        logic [7:0]  e_instr;
        logic [7:0]  e_arg;
        logic [11:0] e_pc;
        logic [3:0]  e_lvl;
        logic [11:0] e_next;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        while (!instr_valid && n < 40) begin
            tick();
            n++;
        end
        chk("issue_seen", {31'b0, instr_valid}, 32'd1);
    endtask

    // Holds off acceptance for 'hold' cycles, accepts, then sends one command in EXEC
    task automatic exec(input logic [2:0] op, input logic [11:0] tgt, input int hold);
        logic [7:0]  s_i, s_a;
        logic [11:0] s_p;
        int          errs;
        s_i = instr_out; s_a = arg_out; s_p = instr_pc; errs = 0;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (instr_out !== s_i || arg_out !== s_a || instr_pc !== s_p) errs++;
            if (mem_rd_en !== 1'b0 || instr_valid !== 1'b1) errs++;
        end
        if (hold > 0) chk("bp_stable", errs, 0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("exec_ctrl_ready", {31'b0, ctrl_ready}, 32'd1);
        chk("single_accept", {31'b0, instr_valid}, 32'd0);
        ctrl_valid = 1'b1; ctrl_op = op; ctrl_target = tgt;
        tick();
        ctrl_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_instr"}, instr_out, 0);
        chk({tag, "_arg"}, arg_out, 0);
        chk({tag, "_pc"}, instr_pc, 0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 0);
        chk({tag, "_ctrl_rdy"}, {31'b0, ctrl_ready}, 0);
        chk({tag, "_rd_en"}, {31'b0, mem_rd_en}, 0);
        chk({tag, "_halted"}, {31'b0, halted}, 0);
        chk({tag, "_err"}, stack_err, 0);
        chk({tag, "_lvl"}, stack_level, 0);
    endtask

    task automatic release_and_check(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_restart_addr"}, mem_addr, 0);
        chk({tag, "_restart_rd"}, {31'b0, mem_rd_en}, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; instr_ready = 1'b0; ctrl_valid = 1'b0; ctrl_op = 3'd0; ctrl_target = '0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[12'h000] = 8'h05; mem[12'h001] = 8'h85; mem[12'h002] = 8'h33; mem[12'h003] = 8'h01;
        mem[12'h00E] = 8'h81; mem[12'h00F] = 8'h44; mem[12'h010] = 8'h02;
        mem[12'h020] = 8'h90; mem[12'h021] = 8'h11; mem[12'h022] = 8'h07; mem[12'h023] = 8'h09;
        mem[12'h100] = 8'hA0; mem[12'h101] = 8'h22; mem[12'h102] = 8'h06;
        mem[12'h200] = 8'h04; mem[12'h300] = 8'h0A; mem[12'hFFF] = 8'h83;

        //             op    tgt      hold instr  arg    pc       lvl  next
        vecs[0]  = '{3'd0, 12'h000, 0, 8'h05, 8'h00, 12'h000, 4'd0, 12'h001};
        vecs[1]  = '{3'd0, 12'h000, 5, 8'h85, 8'h33, 12'h001, 4'd0, 12'h003};
        vecs[2]  = '{3'd1, 12'h010, 0, 8'h01, 8'h00, 12'h003, 4'd0, 12'h010};
        vecs[3]  = '{3'd2, 12'hFFE, 0, 8'h02, 8'h00, 12'h010, 4'd0, 12'h00E};
        vecs[4]  = '{3'd1, 12'hFFF, 0, 8'h81, 8'h44, 12'h00E, 4'd0, 12'hFFF};
        vecs[5]  = '{3'd2, 12'h002, 0, 8'h83, 8'h05, 12'hFFF, 4'd0, 12'h001};
        vecs[6]  = '{3'd1, 12'h020, 0, 8'h85, 8'h33, 12'h001, 4'd0, 12'h020};
        vecs[7]  = '{3'd3, 12'h100, 0, 8'h90, 8'h11, 12'h020, 4'd1, 12'h100};
        vecs[8]  = '{3'd3, 12'h200, 0, 8'hA0, 8'h22, 12'h100, 4'd2, 12'h200};
        vecs[9]  = '{3'd4, 12'h000, 0, 8'h04, 8'h00, 12'h200, 4'd1, 12'h102};
        vecs[10] = '{3'd4, 12'h000, 0, 8'h06, 8'h00, 12'h102, 4'd0, 12'h022};
        vecs[11] = '{3'd6, 12'h000, 0, 8'h07, 8'h00, 12'h022, 4'd0, 12'h023};

        tick();
        tick();
        chk_reset_vals("rst0");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            wait_issue(n);
            if (i == 0) chk("first_latency", n, 2);
            chk($sformatf("v%0d_instr", i), instr_out, vecs[i].e_instr);
            chk($sformatf("v%0d_arg", i), arg_out, vecs[i].e_arg);
            chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].e_pc);
            exec(vecs[i].op, vecs[i].tgt, vecs[i].hold);
            chk($sformatf("v%0d_lvl", i), stack_level, vecs[i].e_lvl);
            chk($sformatf("v%0d_next_addr", i), mem_addr, vecs[i].e_next);
            chk($sformatf("v%0d_next_rd", i), {31'b0, mem_rd_en}, 1);
        end

        // HALT command at 0x023, then reset out of HALT
        wait_issue(n);
        chk("halt_instr", instr_out, 8'h09);
        exec(3'd5, 12'h000, 0);
        tick(); tick();
        chk("halt_halted", {31'b0, halted}, 1);
        chk("halt_rd", {31'b0, mem_rd_en}, 0);
        chk("halt_valid", {31'b0, instr_valid}, 0);
        chk("halt_ctrl_rdy", {31'b0, ctrl_ready}, 0);
        chk("halt_err", stack_err, 0);
        reset = 1'b1;
        tick();
        chk_reset_vals("rst_halt");
        release_and_check("rst_halt");

        // Reset while in LATCH_ARG of the 2-byte instruction at 0x001
        wait_issue(n);
        exec(3'd0, 12'h000, 0);
        chk("la_fetch_addr", mem_addr, 12'h001);
        tick();
        chk("la_arg_addr", mem_addr, 12'h002);
        chk("la_arg_rd", {31'b0, mem_rd_en}, 1);
        tick();
        chk("la_in_latch_arg", {31'b0, mem_rd_en}, 0);
        reset = 1'b1;
        tick();
        chk_reset_vals("rst_la");
        release_and_check("rst_la");
        wait_issue(n);
        chk("post_rst_instr", instr_out, 8'h05);
        chk("post_rst_arg", arg_out, 8'h00);

        // Overflow: STACK_DEPTH+1 calls from a 1-byte instruction at 0x300
        exec(3'd1, 12'h300, 0);
        for (int c = 0; c < 8; c++) begin
            wait_issue(n);
            exec(3'd3, 12'h300, 0);
        end
        chk("ovf_full_lvl", stack_level, 8);
        chk("ovf_full_err", stack_err, 0);
        wait_issue(n);
        exec(3'd3, 12'h300, 0);
        chk("ovf_err", stack_err, 2'b01);
        chk("ovf_halted", {31'b0, halted}, 1);
        chk("ovf_lvl", stack_level, 8);
        chk("ovf_rd", {31'b0, mem_rd_en}, 0);

        // Underflow: RET on an empty stack straight after reset
        reset = 1'b1;
        tick();
        chk("unf_rst_lvl", stack_level, 0);
        reset = 1'b0;
        wait_issue(n);
        exec(3'd4, 12'h000, 0);
        chk("unf_err", stack_err, 2'b10);
        chk("unf_halted", {31'b0, halted}, 1);
        chk("unf_lvl", stack_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
